// File: rtl/pbi_pkg.sv
// Shared constants, FSM state type and select-value helper for the PBI device-select controller.
package pbi_pkg;

   localparam logic [15:0] ADDR_SEL     = 16'hD1FF;
   localparam logic [15:0] ADDR_EXT_LO  = 16'hD100;
   localparam logic [15:0] ADDR_EXT_HI  = 16'hD1FE;
   localparam logic [15:0] ADDR_MATH_LO = 16'hD800;
   localparam logic [15:0] ADDR_MATH_HI = 16'hDFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   // Isolates the lowest set bit so that only one device is ever enabled.
   function automatic logic [7:0] lowest_set(input logic [7:0] v);
      return v & (~v + 8'd1);
   endfunction

endpackage

// File: rtl/pbi_sync.sv
// Two-flop synchronizer for asynchronous inputs, per-bit reset value selectable.
module pbi_sync #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            meta_q[gi] <= RST_VAL[gi];
            sync_q[gi] <= RST_VAL[gi];
         end else begin
            meta_q[gi] <= d_i[gi];
            sync_q[gi] <= meta_q[gi];
         end
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pbi_select_ctrl.sv
// PBI device-select controller: tracks host Phi2 cycles, latches writes to $D1FF into a
// one-hot device enable, and drives the status read-back, math-pack/ext-select and IRQ lines.
module pbi_select_ctrl
   import pbi_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        phi2_i,
   input  logic        rw_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  data_in_i,
   output logic [7:0]  data_out_o,
   output logic        data_oe_o,
   input  logic [7:0]  dev_irq_n_i,
   output logic [7:0]  dev_en_o,
   output logic        mpd_n_o,
   output logic        extsel_n_o,
   output logic        irq_n_o
);

   logic       phi2_s;
   logic [7:0] irq_n_s;

   pbi_sync #(.W(1), .RST_VAL(1'b0)) u_sync_phi2 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (phi2_i),
      .q_o     (phi2_s)
   );

   pbi_sync #(.W(8), .RST_VAL(8'hFF)) u_sync_irq (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (dev_irq_n_i),
      .q_o     (irq_n_s)
   );

   state_e     state_q;
   logic [7:0] dev_en_q;
   logic [7:0] pend_val_q;
   logic       pend_flag_q;
   logic       phi2_dly_q;
   logic       rise_q;
   logic       fall_q;
   logic       rise_hold_q;

   logic sel_hit;
   logic ext_hit;
   logic active;

   assign sel_hit = (addr_i == ADDR_SEL);
   assign ext_hit = ((addr_i >= ADDR_MATH_LO) && (addr_i <= ADDR_MATH_HI)) ||
                    ((addr_i >= ADDR_EXT_LO)  && (addr_i <= ADDR_EXT_HI));
   assign active  = (state_q == ST_ACTIVE);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         dev_en_q    <= 8'h00;
         pend_val_q  <= 8'h00;
         pend_flag_q <= 1'b0;
         phi2_dly_q  <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         rise_hold_q <= 1'b0;
      end else begin
         phi2_dly_q <= phi2_s;
         rise_q     <= phi2_s & ~phi2_dly_q;
         fall_q     <= ~phi2_s & phi2_dly_q;
         case (state_q)
            ST_IDLE: begin
               // A stray fall here is simply not looked at.
               if (rise_q || rise_hold_q) state_q <= ST_ACTIVE;
               rise_hold_q <= 1'b0;
            end
            ST_ACTIVE: begin
               if (sel_hit && !rw_i) begin
                  pend_val_q  <= data_in_i;
                  pend_flag_q <= 1'b1;
               end
               if (fall_q) state_q <= ST_COMMIT;
            end
            ST_COMMIT: begin
               if (pend_flag_q) dev_en_q <= lowest_set(pend_val_q);
               pend_flag_q <= 1'b0;
               // Remember a back-to-back rise so the next cycle is not lost.
               if (rise_q) rise_hold_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_oe_o  = active && rw_i && sel_hit;
   assign data_out_o = data_oe_o ? (~irq_n_s & dev_en_q) : 8'h00;
   assign dev_en_o   = dev_en_q;
   assign mpd_n_o    = ~(|dev_en_q);
   assign extsel_n_o = ~(active && (|dev_en_q) && ext_hit);
   assign irq_n_o    = &irq_n_s;

endmodule
